// File: rtl/week6_ex1_priority_encoder_q.sv
// rtl/week6_ex1_priority_encoder_q.sv - registered priority encoder that serialises sticky request pulses
//
// Optional feature macro: RR_ARB_EN
//   defined   -> round-robin selection starting at an internal pointer
//   undefined -> fixed priority, lowest index wins
//
// Parameters:
//   N  number of request lines (N >= 2)
//   W  output index width, $clog2(N); leave at default
//
// Ports:
//   clk        in   1  rising-edge clock
//   rst_n      in   1  asynchronous active-low reset
//   req        in   N  request pulses, sampled every rising edge
//   out_ready  in   1  consumer accepts out_idx when high with out_valid
//   out_valid  out  1  out_idx holds a granted request
//   out_idx    out  W  binary index of the granted request
//   busy       out  1  high while undelivered requests remain in the pending vector

module week6_ex1_priority_encoder_q #(
  parameter int N = 4,
  parameter int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  input  logic         out_ready,
  output logic         out_valid,
  output logic [W-1:0] out_idx,
  output logic         busy
);

  logic [N-1:0] r_pending;
  logic         r_valid;
  logic [W-1:0] r_idx;

  logic [N-1:0] w_cand;
  logic         w_load;
  logic [W-1:0] w_sel;
  logic [N-1:0] w_sel_mask;

  // Requests arriving this cycle compete alongside those already pending.
  assign w_cand     = r_pending | req;
  // The output register can take a new entry when empty or being drained.
  assign w_load     = !r_valid || out_ready;
  assign w_sel_mask = N'(1) << w_sel;

`ifdef RR_ARB_EN
  logic [W-1:0] r_ptr;
  int           w_dist;
  int           w_best;

  // Each set bit is ranked by its upward distance from the pointer (with
  // wrap); the nearest one wins, which is the first hit of a circular scan.
  always_comb begin
    w_sel  = '0;
    w_best = N;
    w_dist = 0;
    for (int i = 0; i < N; i++) begin
      w_dist = i - int'(r_ptr);
      if (w_dist < 0) begin
        w_dist = w_dist + N;
      end
      if (w_cand[i] && (w_dist < w_best)) begin
        w_best = w_dist;
        w_sel  = W'(i);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= '0;
    end else if (w_load && (|w_cand)) begin
      r_ptr <= (w_sel == W'(N - 1)) ? '0 : w_sel + W'(1);
    end
  end
`else
  // Scan downward so the lowest set index is the last assignment to stick.
  always_comb begin
    w_sel = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (w_cand[i]) begin
        w_sel = W'(i);
      end
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid   <= 1'b0;
      r_idx     <= '0;
      r_pending <= '0;
    end else if (w_load) begin
      if (|w_cand) begin
        r_valid   <= 1'b1;
        r_idx     <= w_sel;
        r_pending <= w_cand & ~w_sel_mask;
      end else begin
        // Nothing to present: drop valid, keep the last index value.
        r_valid   <= 1'b0;
        r_pending <= '0;
      end
    end else begin
      // Stalled: presented entry is frozen, new requests merge into pending,
      // including one matching the presented index (it is delivered again).
      r_pending <= r_pending | req;
    end
  end

  assign out_valid = r_valid;
  assign out_idx   = r_idx;
  assign busy      = |r_pending;

endmodule

// File: tb/tb_week6_ex1_priority_encoder_q.sv
// tb/tb_week6_ex1_priority_encoder_q.sv - self-checking bench for week6_ex1_priority_encoder_q

module tb_week6_ex1_priority_encoder_q;

  localparam int N = 4;
  localparam int W = 2;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic [N-1:0] req = '0;
  logic         out_ready = 1'b0;
  logic         out_valid;
  logic [W-1:0] out_idx;
  logic         busy;

  int n_chk  = 0;
  int n_fail = 0;

  logic [N-1:0] m_pend;
  bit           m_valid;
  int           m_idx;
  int           m_ptr;

  week6_ex1_priority_encoder_q #(.N(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_idx   (out_idx),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input logic [N-1:0] c);
    int start;
`ifdef RR_ARB_EN
    start = m_ptr;
`else
    start = 0;
`endif
    for (int k = 0; k < N; k++) begin
      int j;
      j = (start + k) % N;
      if (((c >> j) & 1) != 0) return j;
    end
    return 0;
  endfunction

  task automatic model_reset();
    m_pend  = '0;
    m_valid = 1'b0;
    m_idx   = 0;
    m_ptr   = 0;
  endtask

  task automatic model_step();
    logic [N-1:0] cand;
    int s;
    cand = m_pend | req;
    if (!m_valid || out_ready) begin
      if (cand != 0) begin
        s       = pick(cand);
        m_idx   = s;
        m_valid = 1'b1;
        m_pend  = cand & ~(N'(1) << s);
        m_ptr   = (s + 1) % N;
      end else begin
        m_valid = 1'b0;
      end
    end else begin
      m_pend = m_pend | req;
    end
  endtask

  task automatic model_chk();
    chk("model_valid", 32'(out_valid), 32'(m_valid));
    chk("model_idx",   32'(out_idx),   32'(m_idx));
    chk("model_busy",  32'(busy),      32'(m_pend != 0));
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    model_chk();
  endtask

  initial begin
    model_reset();
    #2 rst_n = 1'b0;
    #1;
    chk("reset_valid", 32'(out_valid), 32'd0);
    chk("reset_idx",   32'(out_idx),   32'd0);
    chk("reset_busy",  32'(busy),      32'd0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;

`ifdef RR_ARB_EN
    out_ready = 1'b1;
    req = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      cycle();
      chk("rr_seq", 32'(out_idx), 32'(k % 4));
    end
    req = '0;
    #2 rst_n = 1'b0;
    model_reset();
    #1 rst_n = 1'b1;
`endif

    // Single requests, ready held high
    out_ready = 1'b1;
    for (int k = 0; k < N; k++) begin
      req = N'(1) << k;
      cycle();
      chk("single_valid", 32'(out_valid), 32'd1);
      chk("single_idx",   32'(out_idx),   32'(k));
    end
    req = '0;
    cycle();
    chk("single_idle", 32'(out_valid), 32'd0);

    // Multi-hot one-cycle pulse
    req = 4'b1010;
    cycle();
    chk("multi_idx0", 32'(out_idx), 32'd1);
    chk("multi_busy0", 32'(busy), 32'd1);
    req = '0;
    cycle();
    chk("multi_idx1", 32'(out_idx), 32'd3);
    cycle();
    chk("multi_done_valid", 32'(out_valid), 32'd0);
    chk("multi_done_busy",  32'(busy),      32'd0);

    // Backpressure
    out_ready = 1'b0;
    req = 4'b0110;
    cycle();
    req = '0;
    for (int k = 0; k < 5; k++) begin
      cycle();
      chk("bp_idx",  32'(out_idx), 32'd1);
      chk("bp_busy", 32'(busy),    32'd1);
    end
    out_ready = 1'b1;
    cycle();
    chk("bp_next", 32'(out_idx), 32'd2);
    cycle();
    chk("bp_drained", 32'(out_valid), 32'd0);

    // Asynchronous reset while stalled with pending entries
    out_ready = 1'b0;
    req = 4'b1101;
    cycle();
    req = '0;
    cycle();
    chk("pre_reset_busy", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk("async_valid", 32'(out_valid), 32'd0);
    chk("async_idx",   32'(out_idx),   32'd0);
    chk("async_busy",  32'(busy),      32'd0);
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cycle();
      chk("post_reset_quiet", 32'(out_valid), 32'd0);
    end

    // Merge: repeated pulses of the presented index during a stall
    out_ready = 1'b0;
    req = 4'b0100;
    cycle();
    chk("merge_present", 32'(out_idx), 32'd2);
    for (int k = 0; k < 3; k++) begin
      req = '0;
      cycle();
      req = 4'b0100;
      cycle();
    end
    req = '0;
    cycle();
    chk("merge_busy", 32'(busy), 32'd1);
    out_ready = 1'b1;
    cycle();
    chk("merge_again_valid", 32'(out_valid), 32'd1);
    chk("merge_again_idx",   32'(out_idx),   32'd2);
    chk("merge_again_busy",  32'(busy),      32'd0);
    cycle();
    chk("merge_once", 32'(out_valid), 32'd0);

    // Randomised traffic against the reference model
    for (int k = 0; k < 400; k++) begin
      req       = ($urandom_range(0, 2) == 0) ? N'($urandom_range(0, 15)) : '0;
      out_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
